// File: rtl/custom_conv_ctrl_pkg.sv
// Shared definitions for the 2x2-convolution sequencer: geometry constants,
// state encoding, index types and the one-hot helper used for all strobes.
`timescale 1ns/1ps
package custom_conv_ctrl_pkg;

    localparam int FMAP_DIM = 3;  // feature map is FMAP_DIM x FMAP_DIM, row-major
    localparam int KER_DIM  = 2;  // kernel is KER_DIM x KER_DIM
    localparam int N_ALU    = 4;  // one multiplier per kernel tap
    localparam int N_OUT    = 4;  // outputs c11, c12, c21, c22

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_F,
        ST_DRAIN,
        ST_ACC,
        ST_DONE
    } state_t;

    typedef logic [$clog2(N_ALU)-1:0] k_idx_t;  // kernel tap index (a,b) = (k[1],k[0])
    typedef logic [$clog2(N_OUT)-1:0] p_idx_t;  // output index (r,c) = (p[1],p[0])

    // Index 0 maps to the MSB: bit3 is ALU1 / c11, bit0 is ALU4 / c22.
    function automatic logic [N_ALU-1:0] onehot_msb(input logic [1:0] idx);
        return {1'b1, {(N_ALU-1){1'b0}}} >> idx;
    endfunction

endpackage

// File: rtl/custom_conv_ctrl_if.sv
// Controller-to-datapath/memory bundle. The sequencer drives everything except
// start; the datapath, memory and run requester sit on the slave side.
`timescale 1ns/1ps
interface custom_conv_ctrl_if #(parameter int ADDR_W = 8);
    import custom_conv_ctrl_pkg::*;

    logic                              start;
    logic                              busy;
    logic                              done;
    logic [ADDR_W-1:0]                 mem_addr;
    logic                              mem_rd_en;
    logic [N_ALU-1:0]                  weight_en;
    logic [N_ALU-1:0]                  feature_en;
    logic [N_ALU-1:0]                  buff_mux_sel;
    logic [N_OUT*$clog2(N_OUT)-1:0]    sel_demux;
    logic [N_OUT-1:0]                  acc_en;

    modport master (
        input  start,
        output busy, done, mem_addr, mem_rd_en,
        output weight_en, feature_en, buff_mux_sel, sel_demux, acc_en
    );

    modport slave (
        output start,
        input  busy, done, mem_addr, mem_rd_en,
        input  weight_en, feature_en, buff_mux_sel, sel_demux, acc_en
    );

endinterface

// File: rtl/custom_conv_addr_gen.sv
// Read-address generator: weights are contiguous from WGT_BASE; feature tap
// (a,b) of output (r,c) lives at FMAP_BASE + FMAP_DIM*(r+a) + (c+b).
// Arithmetic is ADDR_W wide and wraps freely.
`timescale 1ns/1ps
module custom_conv_addr_gen
    import custom_conv_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] FMAP_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] WGT_BASE  = 8'h10
) (
    input  state_t            phase,
    input  p_idx_t            p,
    input  k_idx_t            k,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    // Decode the window position into a row/column and then an address.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        row  = ADDR_W'(int'(p) / KER_DIM + int'(k) / KER_DIM);
        col  = ADDR_W'(int'(p) % KER_DIM + int'(k) % KER_DIM);
        addr = '0;
        case (phase)
            ST_LOAD_W: addr = WGT_BASE + ADDR_W'(k);
            ST_LOAD_F: addr = FMAP_BASE + row * ADDR_W'(FMAP_DIM) + col;
            default:   addr = '0;
        endcase
    end

endmodule

// File: rtl/custom_conv_ctrl.sv
// Sequencer for the 2x2-conv datapath: loads four weights, then for each of
// the four outputs loads its 2x2 feature window, drains the last load and
// fires one accumulate cycle. Every output is a flop fed from the next-state
// decode, so outputs line up with the state they describe.
`timescale 1ns/1ps
module custom_conv_ctrl
    import custom_conv_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] FMAP_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] WGT_BASE  = 8'h10
) (
    input  logic                clk,
    input  logic                rst,   // asynchronous, active-low
    custom_conv_ctrl_if.master  bus
);

    state_t            state, nxt_state;
    k_idx_t            k, nxt_k;
    p_idx_t            p, nxt_p;
    logic [ADDR_W-1:0] nxt_addr;

    // Read-return tracking: which buffer the read issued last cycle targets.
    logic              rd_is_w_q;
    k_idx_t            rd_k_q;

    custom_conv_addr_gen #(
        .ADDR_W    (ADDR_W),
        .FMAP_BASE (FMAP_BASE),
        .WGT_BASE  (WGT_BASE)
    ) u_addr_gen (
        .phase (nxt_state),
        .p     (nxt_p),
        .k     (nxt_k),
        .addr  (nxt_addr)
    );

    // State and tap/output counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            k     <= '0;
            p     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= nxt_state;
            k     <= nxt_k;
            p     <= nxt_p;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_p     = p;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    nxt_state = ST_LOAD_W;
                    nxt_k     = '0;
                    nxt_p     = '0;
                end
            end
            ST_LOAD_W: begin
                nxt_k = k + k_idx_t'(1);
                if (k == k_idx_t'(N_ALU - 1)) begin
                    nxt_state = ST_LOAD_F;
                    nxt_k     = '0;
                end
            end
            ST_LOAD_F: begin
                nxt_k = k + k_idx_t'(1);
                if (k == k_idx_t'(N_ALU - 1)) begin
                    nxt_state = ST_DRAIN;
                    nxt_k     = '0;
                end
            end
            ST_DRAIN: nxt_state = ST_ACC;
            ST_ACC: begin
                if (p == p_idx_t'(N_OUT - 1)) begin
                    nxt_state = ST_DONE;
                end else begin
                    nxt_state = ST_LOAD_F;
                    nxt_p     = p + p_idx_t'(1);
                    nxt_k     = '0;
                end
            end
            ST_DONE: nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Registered control outputs; buffer loads trail their read strobe by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_rd_en    <= 1'b0;
            bus.weight_en    <= '0;
            bus.feature_en   <= '0;
            bus.buff_mux_sel <= '0;
            bus.sel_demux    <= '0;
            bus.acc_en       <= '0;
            rd_is_w_q        <= 1'b0;
            rd_k_q           <= '0;
        end else begin
            bus.busy         <= nxt_state inside {ST_LOAD_W, ST_LOAD_F, ST_DRAIN, ST_ACC};
            bus.done         <= (nxt_state == ST_DONE);
            bus.mem_rd_en    <= nxt_state inside {ST_LOAD_W, ST_LOAD_F};
            bus.mem_addr     <= nxt_addr;
            rd_is_w_q        <= (nxt_state == ST_LOAD_W);
            rd_k_q           <= nxt_k;
            bus.weight_en    <= (bus.mem_rd_en &&  rd_is_w_q) ? onehot_msb(rd_k_q) : '0;
            bus.feature_en   <= (bus.mem_rd_en && !rd_is_w_q) ? onehot_msb(rd_k_q) : '0;
            bus.buff_mux_sel <= (nxt_state == ST_ACC) ? '1 : '0;
            bus.sel_demux    <= (nxt_state == ST_ACC) ? {N_OUT{nxt_p}} : '0;
            bus.acc_en       <= (nxt_state == ST_ACC) ? onehot_msb(nxt_p) : '0;
        end
    end

endmodule

// File: tb/tb_custom_conv_ctrl.sv
// Bench for custom_conv_ctrl: two instances (plain and wrapping base addresses)
// share one start/reset; a behavioural memory + datapath hangs off the first.
// Expected per-cycle outputs come from the run schedule written as a cycle list.
`timescale 1ns/1ps
module tb_custom_conv_ctrl;
    import custom_conv_ctrl_pkg::*;

    localparam logic [7:0] FB0 = 8'h00, WB0 = 8'h10;
    localparam logic [7:0] FB1 = 8'hFC, WB1 = 8'hFE;
    localparam int K_NONE = 0, K_W = 1, K_F = 2, K_DRAIN = 3, K_ACC = 4, K_DONE = 5;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd;
        logic [7:0] addr;
        logic [3:0] wen;
        logic [3:0] fen;
        logic [3:0] mux;
        logic [7:0] demux;
        logic [3:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    custom_conv_ctrl_if #(.ADDR_W(8)) bus0 ();
    custom_conv_ctrl_if #(.ADDR_W(8)) bus1 ();
    assign bus1.start = bus0.start;

    custom_conv_ctrl #(.ADDR_W(8), .FMAP_BASE(FB0), .WGT_BASE(WB0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    custom_conv_ctrl #(.ADDR_W(8), .FMAP_BASE(FB1), .WGT_BASE(WB1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    // Memory and datapath model driven by dut0's controls.
    logic [7:0] mem [256];
    logic [7:0] data_in;
    logic [7:0] wbuf [4];
    logic [7:0] fbuf [4];
    int         c_acc [4];
    int         dot;
    logic       acc_clr;

    always_comb begin
        dot = 0;
        for (int i = 0; i < 4; i++)
            if (bus0.buff_mux_sel[3-i]) dot += int'(wbuf[i]) * int'(fbuf[i]);
    end

    always @(posedge clk) begin
        if (bus0.mem_rd_en) data_in <= mem[bus0.mem_addr];
        for (int i = 0; i < 4; i++) begin
            if (bus0.weight_en[3-i])  wbuf[i] <= data_in;
            if (bus0.feature_en[3-i]) fbuf[i] <= data_in;
            if (acc_clr)              c_acc[i] <= 0;
            else if (bus0.acc_en[3-i]) c_acc[i] <= c_acc[i] + dot;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Run schedule, t = cycles after the start-sampling edge:
    // 1..4 weight reads, then per output 4 feature reads, drain, accumulate; 29 done.
    function automatic void slot(input int t, output int kind, output int k, output int p);
        int u;
        kind = K_NONE; k = 0; p = 0;
        if (t >= 1 && t <= 4) begin
            kind = K_W; k = t - 1;
        end else if (t >= 5 && t <= 28) begin
            u = t - 5; p = u / 6; k = u % 6;
            kind = (k < 4) ? K_F : ((k == 4) ? K_DRAIN : K_ACC);
        end else if (t == 29) begin
            kind = K_DONE;
        end
    endfunction

    function automatic exp_t expect_at(input int t, input int fb, input int wb);
        exp_t e;
        int kind, k, p, pkind, pk, pp;
        e = '0;
        slot(t, kind, k, p);
        e.busy = (t >= 1 && t <= 28);
        e.done = (kind == K_DONE);
        e.rd   = (kind == K_W || kind == K_F);
        if (kind == K_W) e.addr = 8'((wb + k) & 255);
        if (kind == K_F) e.addr = 8'((fb + 3 * (p / 2 + k / 2) + (p % 2 + k % 2)) & 255);
        if (kind == K_ACC) begin
            e.mux   = 4'hF;
            e.demux = {4{2'(p)}};
            e.acc   = 4'(8 >> p);
        end
        slot(t - 1, pkind, pk, pp);
        if (pkind == K_W) e.wen = 4'(8 >> pk);
        if (pkind == K_F) e.fen = 4'(8 >> pk);
        return e;
    endfunction

    function automatic int ref_conv(input int p);
        int s = 0;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                s += int'(mem[(int'(FB0) + 3 * (p / 2 + a) + (p % 2 + b)) & 255])
                   * int'(mem[(int'(WB0) + 2 * a + b) & 255]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input int t, input string tag);
        exp_t e0, e1;
        e0 = expect_at(t, int'(FB0), int'(WB0));
        e1 = expect_at(t, int'(FB1), int'(WB1));
        check($sformatf("%s t=%0d dut0 ctrl", tag, t),
              64'({bus0.busy, bus0.done, bus0.weight_en, bus0.feature_en,
                   bus0.buff_mux_sel, bus0.sel_demux, bus0.acc_en}),
              64'({e0.busy, e0.done, e0.wen, e0.fen, e0.mux, e0.demux, e0.acc}));
        check($sformatf("%s t=%0d dut0 mem", tag, t),
              64'({bus0.mem_rd_en, bus0.mem_addr}), 64'({e0.rd, e0.addr}));
        check($sformatf("%s t=%0d dut1 wrap mem", tag, t),
              64'({bus1.mem_rd_en, bus1.mem_addr}), 64'({e1.rd, e1.addr}));
    endtask

    // One run; start must already be set for the coming edge. rnd_start toggles
    // start randomly while busy; otherwise start stays high. abort_at>0 resets mid-run.
    task automatic do_run(input string tag, input bit rnd_start, input bit next_start,
                          input int abort_at);
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t == 1) acc_clr = 1'b0;
            check_cycle(t, tag);
            if (t == abort_at) begin
                #2 rst = 1'b0;
                #1 check_cycle(0, {tag, " async reset"});
                bus0.start = 1'b0;
                #2 rst = 1'b1;
                return;
            end
            if (t < 30) begin
                bus0.start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                for (int p = 0; p < 4; p++)
                    check($sformatf("%s conv c%0d", tag, p), 64'(c_acc[p]), 64'(ref_conv(p)));
                bus0.start = next_start;
                acc_clr    = next_start;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        rst        = 1'b0;
        bus0.start = 1'b0;
        acc_clr    = 1'b1;
        fill_random();
        for (int i = 0; i < 9; i++) mem[int'(FB0) + i] = 8'(i + 1);
        mem[WB0 + 0] = 8'd1; mem[WB0 + 1] = 8'd0; mem[WB0 + 2] = 8'd0; mem[WB0 + 3] = 8'd1;

        // Outputs held at zero in reset, and stay idle after release without start.
        #3 check_cycle(0, "in reset");
        #20 rst = 1'b1;
        repeat (2) begin
            tick();
            check_cycle(0, "idle");
        end

        // Directed run: identity-diagonal kernel over 1..9.
        bus0.start = 1'b1; acc_clr = 1'b1;
        do_run("directed", 1'b1, 1'b0, 0);
        check("c11", 64'(c_acc[0]), 64'd6);
        check("c12", 64'(c_acc[1]), 64'd8);
        check("c21", 64'(c_acc[2]), 64'd12);
        check("c22", 64'(c_acc[3]), 64'd14);

        // Reset during LOAD_F aborts with no done pulse; a clean run follows.
        tick(); check_cycle(0, "post run idle");
        bus0.start = 1'b1; acc_clr = 1'b1;
        do_run("abort", 1'b1, 1'b0, 8);
        repeat (3) begin
            tick();
            check_cycle(0, "after abort");
        end
        fill_random();
        bus0.start = 1'b1; acc_clr = 1'b1;
        do_run("after abort", 1'b1, 1'b0, 0);

        // start held high: three back-to-back runs.
        fill_random();
        bus0.start = 1'b1; acc_clr = 1'b1;
        do_run("held1", 1'b0, 1'b1, 0);
        do_run("held2", 1'b0, 1'b1, 0);
        do_run("held3", 1'b0, 1'b0, 0);

        // Random data, random idle gaps, random start noise while busy.
        repeat (3) begin
            fill_random();
            repeat ($urandom_range(1, 4)) begin
                tick();
                check_cycle(0, "gap");
            end
            bus0.start = 1'b1; acc_clr = 1'b1;
            do_run("random", 1'b1, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
